// File: rtl/debounce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce_pkg : shared state encoding and width helper for debouncer  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  // Ceiling log2; returns the bit count needed to index 'value' entries.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_chain : SYNC_STAGES-deep metastability synchronizer             |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = r_sync[SYNC_STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/debounce_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce_edge_detect : synchronizer, debouncer and rise/fall strobes |
// | Optional macro DEBOUNCE_TOGGLE_EN builds the toggle_q register.      |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module debounce_edge_detect
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 8
) (
  input  logic CLK,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic settling,
  output logic toggle_q
);

  localparam int c_cnt_w = clog2(STABLE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  generate
    if (SYNC_STAGES < 2 || STABLE_CYCLES < 2) begin : g_param_check
      $error("debounce_edge_detect: SYNC_STAGES and STABLE_CYCLES must both be >= 2");
    end
  endgenerate

  logic w_din_s;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_chain (
    .CLK   (CLK),
    .reset (reset),
    .din   (din),
    .dout  (w_din_s)
  );

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic                 r_q;
  logic                 w_q_nxt;
  logic                 r_rise;
  logic                 w_rise_nxt;
  logic                 r_fall;
  logic                 w_fall_nxt;
  logic                 r_settling;
  logic                 w_settling_nxt;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_state    <= S_LOW;
      r_cnt      <= '0;
      r_q        <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_settling <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_q        <= w_q_nxt;
      r_rise     <= w_rise_nxt;
      r_fall     <= w_fall_nxt;
      r_settling <= w_settling_nxt;
    end
  end

  // Any opposite sample while qualifying falls back to the stable state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    unique case (r_state)
      S_LOW: begin
        if (w_din_s) begin
          w_state_nxt = S_RISE;
          w_cnt_nxt   = c_cnt_one;
        end
      end
      S_RISE: begin
        if (!w_din_s) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
          w_q_nxt     = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_cnt_one;
        end
      end
      S_HIGH: begin
        if (!w_din_s) begin
          w_state_nxt = S_FALL;
          w_cnt_nxt   = c_cnt_one;
        end
      end
      S_FALL: begin
        if (w_din_s) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
          w_q_nxt     = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = '0;
        w_q_nxt     = 1'b0;
      end
    endcase
  end

  assign w_settling_nxt = (w_state_nxt == S_RISE) || (w_state_nxt == S_FALL);

  assign q        = r_q;
  assign rise     = r_rise;
  assign fall     = r_fall;
  assign settling = r_settling;

`ifdef DEBOUNCE_TOGGLE_EN
  logic r_toggle;

  // Flips on the same edge that raises the rise strobe.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_toggle <= 1'b0;
    end else if (w_rise_nxt) begin
      r_toggle <= ~r_toggle;
    end
  end

  assign toggle_q = r_toggle;
`else
  assign toggle_q = 1'b0;
`endif

endmodule : debounce_edge_detect
`default_nettype wire
